// File: rtl/sdram_responder.sv
// SDR SDRAM device responder: decodes the command bus, tracks bank rows,
// serves a word array and returns reads at the programmed CAS latency.
module sdram_responder #(
    parameter int MEM_AW = 12,
    parameter int TRCD   = 3
) (
    input  logic        clk,
    input  logic        init_n,
    input  logic        sd_ncs,
    input  logic        sd_nras,
    input  logic        sd_ncas,
    input  logic        sd_nwe,
    input  logic [12:0] sd_a,
    input  logic [1:0]  sd_ba,
    input  logic        sd_dqml,
    input  logic        sd_dqmh,
    input  logic [15:0] sd_dq_in,
    output logic [15:0] sd_dq_out,
    output logic [1:0]  sd_dq_oe,
    output logic [12:0] mode_reg,
    output logic [15:0] refresh_cnt,
    output logic [5:0]  err
);

    localparam int CW    = $clog2(TRCD + 1);
    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic [2:0] {
        C_NOP,
        C_ACT,
        C_RD,
        C_WR,
        C_PRE,
        C_REF,
        C_LMR,
        C_BST
    } cmd_e;

    cmd_e              cmd;
    logic [2:0]        rcw;
    logic [3:0]        bk_open;
    logic [12:0]       bk_row [4];
    logic [CW-1:0]     bk_cnt [4];
    logic [MEM_AW-1:0] idx;
    logic [15:0]       mem [DEPTH];
    logic              cl2;
    logic              p1_v;
    logic              p2_v;
    logic [15:0]       p1_d;
    logic [15:0]       p2_d;
    logic              dqmh_q;
    logic              dqml_q;
    logic              o_v;
    logic [15:0]       o_d;

    function automatic logic mode_ok(input logic [12:0] m);
        return ((m[6:4] == 3'd2) || (m[6:4] == 3'd3)) && (m[2:0] == 3'd0);
    endfunction

    assign rcw = {sd_nras, sd_ncas, sd_nwe};
    assign idx = MEM_AW'({sd_ba, bk_row[sd_ba], sd_a[8:0]});
    assign cl2 = mode_ok(mode_reg) && (mode_reg[6:4] == 3'd2);
    assign o_v = cl2 ? p1_v : p2_v;
    assign o_d = cl2 ? p1_d : p2_d;

    // Decode the strobes sampled this edge into one command.
    always_comb begin
        cmd = C_NOP;
        unique case (1'b1)
            sd_ncs:                        cmd = C_NOP;
            !sd_ncs && (rcw == 3'b011):    cmd = C_ACT;
            !sd_ncs && (rcw == 3'b101):    cmd = C_RD;
            !sd_ncs && (rcw == 3'b100):    cmd = C_WR;
            !sd_ncs && (rcw == 3'b010):    cmd = C_PRE;
            !sd_ncs && (rcw == 3'b001):    cmd = C_REF;
            !sd_ncs && (rcw == 3'b000):    cmd = C_LMR;
            !sd_ncs && (rcw == 3'b110):    cmd = C_BST;
            !sd_ncs && (rcw == 3'b111):    cmd = C_NOP;
        endcase
    end

    // Backing store; contents survive reset, DQM write latency is zero.
    always_ff @(posedge clk) begin
        if (init_n && (cmd == C_WR)) begin
            if (!sd_dqml) mem[idx][7:0]  <= sd_dq_in[7:0];
            if (!sd_dqmh) mem[idx][15:8] <= sd_dq_in[15:8];
        end
    end

    // Bank rows, tRCD counters, mode, refresh count and sticky errors.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            bk_open     <= '0;
            for (int b = 0; b < 4; b++) begin
                bk_row[b] <= '0;
                bk_cnt[b] <= CW'(TRCD);
            end
            mode_reg    <= 13'h030;
            refresh_cnt <= '0;
            err         <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (bk_cnt[b] != CW'(TRCD)) bk_cnt[b] <= bk_cnt[b] + 1'b1;
            end
            unique case (cmd)
                C_ACT: begin
                    if (bk_open[sd_ba]) err[1] <= 1'b1;
                    bk_open[sd_ba] <= 1'b1;
                    bk_row[sd_ba]  <= sd_a;
                    bk_cnt[sd_ba]  <= CW'(1);
                end
                C_RD, C_WR: begin
                    if (!bk_open[sd_ba]) err[0] <= 1'b1;
                    else if (bk_cnt[sd_ba] < CW'(TRCD)) err[2] <= 1'b1;
                    if ((cmd == C_WR) && (sd_dq_oe != 2'b00)) err[5] <= 1'b1;
                    if (sd_a[10]) bk_open[sd_ba] <= 1'b0;
                end
                C_PRE: begin
                    if (sd_a[10]) bk_open <= '0;
                    else bk_open[sd_ba] <= 1'b0;
                end
                C_REF: begin
                    refresh_cnt <= refresh_cnt + 16'd1;
                    if (|bk_open) err[3] <= 1'b1;
                end
                C_LMR: begin
                    mode_reg <= sd_a;
                    if (|bk_open) err[3] <= 1'b1;
                    if (!mode_ok(sd_a)) err[4] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Read pipe: capture at the READ edge, drive at edge k+CL-1 with
    // the byte masks sampled one edge earlier (read DQM latency 2).
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            p1_v      <= 1'b0;
            p2_v      <= 1'b0;
            p1_d      <= '0;
            p2_d      <= '0;
            dqmh_q    <= 1'b0;
            dqml_q    <= 1'b0;
            sd_dq_oe  <= '0;
            sd_dq_out <= '0;
        end else begin
            p1_v      <= (cmd == C_RD);
            p1_d      <= mem[idx];
            p2_v      <= p1_v;
            p2_d      <= p1_d;
            dqmh_q    <= sd_dqmh;
            dqml_q    <= sd_dqml;
            sd_dq_oe  <= {o_v & ~dqmh_q, o_v & ~dqml_q};
            sd_dq_out <= {(o_v && !dqmh_q) ? o_d[15:8] : 8'h00,
                          (o_v && !dqml_q) ? o_d[7:0]  : 8'h00};
        end
    end

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: directed scenarios plus random traffic,
// scored against a behavioural model with a decoupled read monitor.
module tb_sdram_responder;

    localparam int TR  = 3;
    localparam int HMX = 8192;

    localparam logic [2:0] ACT = 3'b011;
    localparam logic [2:0] RD  = 3'b101;
    localparam logic [2:0] WR  = 3'b100;
    localparam logic [2:0] PRE = 3'b010;
    localparam logic [2:0] REF = 3'b001;
    localparam logic [2:0] LMR = 3'b000;
    localparam logic [2:0] NOP = 3'b111;

    logic        clk = 1'b0;
    logic        init_n = 1'b0;
    logic        sd_ncs = 1'b1;
    logic        sd_nras = 1'b1;
    logic        sd_ncas = 1'b1;
    logic        sd_nwe = 1'b1;
    logic [12:0] sd_a = '0;
    logic [1:0]  sd_ba = '0;
    logic        sd_dqml = 1'b0;
    logic        sd_dqmh = 1'b0;
    logic [15:0] sd_dq_in = '0;
    logic [15:0] sd_dq_out;
    logic [1:0]  sd_dq_oe;
    logic [12:0] mode_reg;
    logic [15:0] refresh_cnt;
    logic [5:0]  err;

    sdram_responder #(.MEM_AW(12), .TRCD(TR)) dut (
        .clk(clk), .init_n(init_n), .sd_ncs(sd_ncs), .sd_nras(sd_nras),
        .sd_ncas(sd_ncas), .sd_nwe(sd_nwe), .sd_a(sd_a), .sd_ba(sd_ba),
        .sd_dqml(sd_dqml), .sd_dqmh(sd_dqmh), .sd_dq_in(sd_dq_in),
        .sd_dq_out(sd_dq_out), .sd_dq_oe(sd_dq_oe), .mode_reg(mode_reg),
        .refresh_cnt(refresh_cnt), .err(err)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int failures = 0;

    // behavioural model state
    logic [15:0] mem_m [4096];
    bit          vh_m [4096];
    bit          vl_m [4096];
    bit          m_open [4];
    logic [12:0] m_row [4];
    int          m_act [4];
    logic [5:0]  m_err;
    logic [12:0] m_mode;
    logic [15:0] m_ref;
    bit          dqmh_h [HMX];
    bit          dqml_h [HMX];
    bit          rd_at [HMX];

    typedef struct {
        int          due;
        logic [15:0] d;
        bit          dc;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s edge=%0d got=%h want=%h", nm, edge_cnt, act, req);
        end
    endtask

    function automatic int mcl();
        if (m_mode[6:4] == 3'd2 && m_mode[2:0] == 3'd0) return 2;
        return 3;
    endfunction

    function automatic int maddr(input logic [1:0] ba, input logic [12:0] row,
                                 input logic [8:0] col);
        logic [23:0] f;
        f = {ba, row, col};
        return int'(f[11:0]);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_open[b] = 0;
            m_row[b]  = '0;
            m_act[b]  = -100;
        end
        m_err  = '0;
        m_mode = 13'h030;
        m_ref  = '0;
    endtask

    task automatic model(input int k, input logic [2:0] c, input logic [1:0] ba,
                         input logic [12:0] a, input bit dh, input bit dl,
                         input logic [15:0] dq);
        int  ix;
        int  due;
        bit  any;
        exp_t e;
        any = m_open[0] | m_open[1] | m_open[2] | m_open[3];
        case (c)
            ACT: begin
                if (m_open[ba]) m_err[1] = 1'b1;
                m_open[ba] = 1;
                m_row[ba]  = a;
                m_act[ba]  = k;
            end
            RD, WR: begin
                ix = maddr(ba, m_row[ba], a[8:0]);
                if (!m_open[ba]) m_err[0] = 1'b1;
                else if (k - m_act[ba] < TR) m_err[2] = 1'b1;
                if (c == WR) begin
                    if (rd_at[k-1] && !(dqmh_h[k-2] && dqml_h[k-2]))
                        m_err[5] = 1'b1;
                    if (!dl) begin mem_m[ix][7:0] = dq[7:0]; vl_m[ix] = 1; end
                    if (!dh) begin mem_m[ix][15:8] = dq[15:8]; vh_m[ix] = 1; end
                end else begin
                    due = k + mcl() - 1;
                    rd_at[due] = 1;
                    e.due = due;
                    e.d   = mem_m[ix];
                    e.dc  = !(vh_m[ix] && vl_m[ix]);
                    sbq.push_back(e);
                end
                if (a[10]) m_open[ba] = 0;
            end
            PRE: begin
                if (a[10]) for (int b = 0; b < 4; b++) m_open[b] = 0;
                else m_open[ba] = 0;
            end
            REF: begin
                m_ref = m_ref + 16'd1;
                if (any) m_err[3] = 1'b1;
            end
            LMR: begin
                if (any) m_err[3] = 1'b1;
                m_mode = a;
                if (!((a[6:4] == 3'd2 || a[6:4] == 3'd3) && a[2:0] == 3'd0))
                    m_err[4] = 1'b1;
            end
            default: ;
        endcase
    endtask

    // one bus cycle: check visible state, then drive the next command
    task automatic issue(input bit ncs, input logic [2:0] c,
                         input logic [1:0] ba = 2'd0, input logic [12:0] a = 13'd0,
                         input bit dh = 1'b0, input bit dl = 1'b0,
                         input logic [15:0] dq = 16'h0);
        int k;
        @(negedge clk);
        chk("err", 32'(err), 32'(m_err));
        chk("mode_reg", 32'(mode_reg), 32'(m_mode));
        chk("refresh_cnt", 32'(refresh_cnt), 32'(m_ref));
        sd_ncs = ncs;
        {sd_nras, sd_ncas, sd_nwe} = c;
        sd_ba = ba;
        sd_a = a;
        sd_dqmh = dh;
        sd_dqml = dl;
        sd_dq_in = dq;
        k = edge_cnt + 1;
        if (k < HMX - 4) begin
            dqmh_h[k] = dh;
            dqml_h[k] = dl;
            if (!ncs && init_n) model(k, c, ba, a, dh, dl, dq);
        end
    endtask

    task automatic cmd(input logic [2:0] c, input logic [1:0] ba = 2'd0,
                       input logic [12:0] a = 13'd0, input bit dh = 1'b0,
                       input bit dl = 1'b0, input logic [15:0] dq = 16'h0);
        issue(1'b0, c, ba, a, dh, dl, dq);
    endtask

    task automatic nop(input int n, input bit dh = 1'b0, input bit dl = 1'b0);
        for (int i = 0; i < n; i++) issue(1'b0, NOP, 2'd0, 13'd0, dh, dl);
    endtask

    // read monitor: every output cycle is matched to the scoreboard
    exp_t        me;
    logic [1:0]  m_oe;
    logic [15:0] m_d;
    always @(negedge clk) begin
        if (sbq.size() != 0 && sbq[0].due == edge_cnt) begin
            me = sbq.pop_front();
            m_oe = {~dqmh_h[me.due-1], ~dqml_h[me.due-1]};
            m_d  = {m_oe[1] ? me.d[15:8] : 8'h00, m_oe[0] ? me.d[7:0] : 8'h00};
            chk("rd_oe", 32'(sd_dq_oe), 32'(m_oe));
            if (!me.dc) chk("rd_data", 32'(sd_dq_out), 32'(m_d));
        end else begin
            chk("idle_oe", 32'(sd_dq_oe), 32'(0));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog edge=%0d got=timeout want=finish", edge_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  rc;
        logic [1:0]  rb;
        logic [12:0] ra;
        int          op;
        model_reset();
        for (int i = 0; i < 4096; i++) begin
            vh_m[i] = 0;
            vl_m[i] = 0;
            mem_m[i] = '0;
        end

        // reset state
        nop(3);
        init_n = 1'b1;
        nop(2);
        chk("reset_mode", 32'(mode_reg), 32'h030);
        chk("reset_err", 32'(err), 32'h0);

        // write then read, CL3
        cmd(ACT, 2, 13'h155);
        nop(2);
        cmd(WR, 2, 13'h412, 0, 0, 16'hBEEF);
        cmd(ACT, 2, 13'h155);
        nop(2);
        cmd(RD, 2, 13'h412);
        nop(4);
        chk("t2_err", 32'(err), 32'h0);

        // byte masks, and a write behind a read in flight
        cmd(ACT, 2, 13'h155);
        nop(2);
        cmd(WR, 2, 13'h412, 1, 0, 16'h1234);
        cmd(ACT, 2, 13'h155);
        nop(2);
        cmd(RD, 2, 13'h012);
        cmd(WR, 2, 13'h012, 0, 1, 16'hAAAA);
        nop(3);
        cmd(PRE, 2, 13'h000);

        // mode change to CL2, then an unsupported mode
        cmd(LMR, 0, 13'h020);
        cmd(ACT, 2, 13'h155);
        nop(2);
        cmd(RD, 2, 13'h412);
        nop(3);
        cmd(LMR, 0, 13'h033);
        chk_mode_later: nop(1);
        chk("t4_mode", 32'(mode_reg), 32'h033);
        cmd(LMR, 0, 13'h030);

        // protocol violations
        cmd(RD, 1, 13'h005);
        cmd(ACT, 3, 13'h001);
        cmd(ACT, 3, 13'h001);
        nop(1);
        cmd(RD, 3, 13'h005);
        nop(3);
        cmd(REF);
        nop(1);
        chk("t5_err", 32'(err), 32'h1F);
        chk("t5_ref", 32'(refresh_cnt), 32'h1);
        cmd(PRE, 0, 13'h400);

        // three-bank interleave
        cmd(ACT, 0, 13'h003); nop(2); cmd(WR, 0, 13'h421, 0, 0, 16'h0A0A);
        cmd(ACT, 2, 13'h005); nop(2); cmd(WR, 2, 13'h433, 0, 0, 16'h2C2C);
        cmd(ACT, 3, 13'h006); nop(2); cmd(WR, 3, 13'h444, 0, 0, 16'h3D3D);
        cmd(ACT, 0, 13'h003);
        cmd(ACT, 2, 13'h005);
        cmd(ACT, 3, 13'h006);
        nop(1);
        cmd(RD, 0, 13'h421);
        cmd(RD, 2, 13'h433);
        cmd(RD, 3, 13'h444);
        nop(5);

        // reset in the middle of a read
        cmd(ACT, 1, 13'h002);
        nop(2);
        cmd(RD, 1, 13'h407);
        @(posedge clk);
        #2;
        init_n = 1'b0;
        #1;
        chk("rst_oe", 32'(sd_dq_oe), 32'h0);
        sbq.delete();
        for (int i = edge_cnt; i < edge_cnt + 6; i++) rd_at[i] = 0;
        model_reset();
        nop(3);
        init_n = 1'b1;
        nop(6);

        // random traffic
        cmd(LMR, 0, ($urandom_range(0, 1) != 0) ? 13'h020 : 13'h030);
        for (int n = 0; n < 1500; n++) begin
            op = $urandom_range(0, 9);
            rb = 2'($urandom_range(0, 3));
            ra = 13'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ra[10] = 1'b1;
            case (op)
                0, 1: begin rc = ACT; ra = 13'($urandom_range(0, 7)); end
                2, 3, 4: rc = RD;
                5, 6, 7: rc = WR;
                8: rc = PRE;
                default: rc = NOP;
            endcase
            cmd(rc, rb, ra, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                16'($urandom));
        end
        nop(6);
        chk("sb_drain", 32'(sbq.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
